// File: rtl/xor_train_ctrl.sv
// Training sequencer and weight bank for the XOR perceptron: walks the four XOR patterns for EPOCHS passes.
// Optional macro XOR_TRAIN_NAN_GUARD_EN blocks Inf/NaN weight writes and raises a sticky oERR.
module xor_train_ctrl #(
  parameter int unsigned EPOCHS      = 1000,
  parameter int unsigned FWD_LATENCY = 30,
  parameter int unsigned UPD_LATENCY = 20,
  parameter logic [31:0] INIT_V0     = 32'h00000000,
  parameter logic [31:0] INIT_V1     = 32'h00000000,
  parameter logic [31:0] INIT_V2     = 32'h00000000,
  parameter logic [31:0] INIT_V12    = 32'h00000000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [31:0] iNEW_V0,
  input  logic [31:0] iNEW_V1,
  input  logic [31:0] iNEW_V2,
  input  logic [31:0] iNEW_V12,
  output logic [31:0] oWEIGHT_V0,
  output logic [31:0] oWEIGHT_V1,
  output logic [31:0] oWEIGHT_V2,
  output logic [31:0] oWEIGHT_V12,
  output logic [31:0] oX1,
  output logic [31:0] oX2,
  output logic [31:0] oTEACH,
  output logic [1:0]  oPATTERN,
  output logic [15:0] oEPOCH,
  output logic        oBUSY,
  output logic        oUPDATE,
  output logic        oDONE,
  output logic        oERR
);

  localparam int unsigned MAX_LAT = (FWD_LATENCY > UPD_LATENCY) ? FWD_LATENCY : UPD_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [31:0] F_ONE   = 32'h3F800000;
  localparam logic [31:0] F_ZERO  = 32'h00000000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FWD   = 3'd1;
  localparam logic [2:0] S_UPD   = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait,  w_wait_nxt;
  logic [1:0]       r_pattern, w_pattern_nxt;
  logic [15:0]      r_epoch, w_epoch_nxt;
  logic             w_latch;
  logic             w_start_ok;

  logic [31:0] r_v0, r_v1, r_v2, r_v12;
  logic [31:0] r_x1, r_x2, r_teach;
  logic        r_busy, r_update, r_done;
  logic        w_bad_v0, w_bad_v1, w_bad_v2, w_bad_v12;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_pattern <= 2'd0;
      r_epoch   <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_pattern <= w_pattern_nxt;
      r_epoch   <= w_epoch_nxt;
    end
  end

  assign w_start_ok = iSTART && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Next-state logic: latency waits, pattern stepping, epoch counting
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_pattern_nxt = r_pattern;
    w_epoch_nxt   = r_epoch;
    w_latch       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (iSTART) begin
          w_state_nxt   = S_FWD;
          w_wait_nxt    = '0;
          w_pattern_nxt = 2'd0;
          w_epoch_nxt   = 16'd0;
        end
      end
      S_FWD: begin
        if (r_wait == CNT_W'(FWD_LATENCY - 1)) begin
          w_state_nxt = S_UPD;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + CNT_W'(1);
        end
      end
      S_UPD: begin
        if (r_wait == CNT_W'(UPD_LATENCY - 1)) begin
          w_state_nxt = S_LATCH;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + CNT_W'(1);
        end
      end
      S_LATCH: begin
        w_latch    = 1'b1;
        w_wait_nxt = '0;
        if (r_pattern == 2'd3) begin
          w_pattern_nxt = 2'd0;
          w_epoch_nxt   = r_epoch + 16'd1;
          w_state_nxt   = ((r_epoch + 16'd1) == 16'(EPOCHS)) ? S_DONE : S_FWD;
        end else begin
          w_pattern_nxt = r_pattern + 2'd1;
          w_state_nxt   = S_FWD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Status flags and pattern decode, registered from the next state
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_busy   <= 1'b0;
      r_update <= 1'b0;
      r_done   <= 1'b0;
      r_x1     <= F_ZERO;
      r_x2     <= F_ZERO;
      r_teach  <= F_ZERO;
    end else begin
      r_busy   <= (w_state_nxt == S_FWD) || (w_state_nxt == S_UPD) || (w_state_nxt == S_LATCH);
      r_update <= (w_state_nxt == S_LATCH);
      r_done   <= (w_state_nxt == S_DONE);
      r_x1     <= w_pattern_nxt[1] ? F_ONE : F_ZERO;
      r_x2     <= w_pattern_nxt[0] ? F_ONE : F_ZERO;
      r_teach  <= (w_pattern_nxt[1] ^ w_pattern_nxt[0]) ? F_ONE : F_ZERO;
    end
  end

`ifdef XOR_TRAIN_NAN_GUARD_EN
  logic r_err;

  // Exponent all-ones means Inf or NaN
  assign w_bad_v0  = &iNEW_V0[30:23];
  assign w_bad_v1  = &iNEW_V1[30:23];
  assign w_bad_v2  = &iNEW_V2[30:23];
  assign w_bad_v12 = &iNEW_V12[30:23];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_latch && (w_bad_v0 || w_bad_v1 || w_bad_v2 || w_bad_v12)) begin
      r_err <= 1'b1;
    end
  end

  assign oERR = r_err;
`else
  assign w_bad_v0  = 1'b0;
  assign w_bad_v1  = 1'b0;
  assign w_bad_v2  = 1'b0;
  assign w_bad_v12 = 1'b0;
  assign oERR      = 1'b0;
`endif

  // Weight bank: written only in LATCH so weights hold across the FWD+UPD window
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_v0  <= INIT_V0;
      r_v1  <= INIT_V1;
      r_v2  <= INIT_V2;
      r_v12 <= INIT_V12;
    end else if (w_latch) begin
      if (!w_bad_v0)  r_v0  <= iNEW_V0;
      if (!w_bad_v1)  r_v1  <= iNEW_V1;
      if (!w_bad_v2)  r_v2  <= iNEW_V2;
      if (!w_bad_v12) r_v12 <= iNEW_V12;
    end
  end

  assign oWEIGHT_V0  = r_v0;
  assign oWEIGHT_V1  = r_v1;
  assign oWEIGHT_V2  = r_v2;
  assign oWEIGHT_V12 = r_v12;
  assign oX1         = r_x1;
  assign oX2         = r_x2;
  assign oTEACH      = r_teach;
  assign oPATTERN    = r_pattern;
  assign oEPOCH      = r_epoch;
  assign oBUSY       = r_busy;
  assign oUPDATE     = r_update;
  assign oDONE       = r_done;

endmodule

// File: tb/tb_xor_train_ctrl.sv
// Randomized bench for xor_train_ctrl against a cycle-position reference model of the training schedule.
module tb_xor_train_ctrl;

  localparam int unsigned EP   = 2;
  localparam int unsigned FL   = 3;
  localparam int unsigned UL   = 4;
  localparam int unsigned PER  = FL + UL + 1;
  localparam logic [31:0] INIT0 = 32'h3F000000;
  localparam logic [31:0] ONE   = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] n0, n1, n2, n12;
  logic [31:0] w0, w1, w2, w12, x1, x2, teach;
  logic [1:0]  pattern;
  logic [15:0] epoch;
  logic        busy, update, done, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_w[4];
  int          m_pat, m_epoch, m_pos;
  bit          m_run, m_done, m_err;

  xor_train_ctrl #(
    .EPOCHS(EP), .FWD_LATENCY(FL), .UPD_LATENCY(UL),
    .INIT_V0(INIT0), .INIT_V1(32'h0), .INIT_V2(32'h0), .INIT_V12(32'h0)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start),
    .iNEW_V0(n0), .iNEW_V1(n1), .iNEW_V2(n2), .iNEW_V12(n12),
    .oWEIGHT_V0(w0), .oWEIGHT_V1(w1), .oWEIGHT_V2(w2), .oWEIGHT_V12(w12),
    .oX1(x1), .oX2(x2), .oTEACH(teach), .oPATTERN(pattern), .oEPOCH(epoch),
    .oBUSY(busy), .oUPDATE(update), .oDONE(done), .oERR(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w[0] = INIT0; m_w[1] = 32'h0; m_w[2] = 32'h0; m_w[3] = 32'h0;
    m_pat = 0; m_epoch = 0; m_pos = 0;
    m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] ex1, ex2;
    ex1 = (m_pat >= 2) ? ONE : 32'h0;
    ex2 = (m_pat % 2 == 1) ? ONE : 32'h0;
    chk("busy",    32'(busy),    32'(m_run));
    chk("update",  32'(update),  32'(m_run && (m_pos % PER == PER - 1)));
    chk("done",    32'(done),    32'(m_done));
    chk("pattern", 32'(pattern), 32'(m_pat));
    chk("epoch",   32'(epoch),   32'(m_epoch));
    chk("x1",      x1,           ex1);
    chk("x2",      x2,           ex2);
    chk("teach",   teach,        (ex1 != ex2) ? ONE : 32'h0);
    chk("w0",      w0,           m_w[0]);
    chk("w1",      w1,           m_w[1]);
    chk("w2",      w2,           m_w[2]);
    chk("w12",     w12,          m_w[3]);
    chk("err",     32'(err),     32'(m_err));
  endtask

  // Apply one weight write from the update stage, honouring the non-finite guard when built in
  task automatic model_latch();
    logic [31:0] nv[4];
    nv[0] = n0; nv[1] = n1; nv[2] = n2; nv[3] = n12;
    for (int i = 0; i < 4; i++) begin
`ifdef XOR_TRAIN_NAN_GUARD_EN
      if (nv[i][30:23] == 8'hFF) m_err = 1'b1;
      else m_w[i] = nv[i];
`else
      m_w[i] = nv[i];
`endif
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_done = 1'b0; m_err = 1'b0;
        m_pos = 0; m_pat = 0; m_epoch = 0;
      end
    end else begin
      if (m_pos % PER == PER - 1) begin
        model_latch();
        m_pat = (m_pat + 1) % 4;
        if (m_pat == 0) begin
          m_epoch++;
          if (m_epoch == EP) begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
      m_pos++;
    end
  endtask

  task automatic drive_random();
    n0  = ($urandom % 4 == 0) ? ONE : $urandom;
    n1  = ($urandom % 2 == 0) ? 32'h40000000 : $urandom;
    n2  = ($urandom % 4 == 0) ? 32'h7FC00000 : $urandom;
    n12 = ($urandom % 8 == 0) ? 32'hFF800000 : $urandom;
  endtask

  task automatic step(input bit st, input bit r);
    @(negedge clk);
    check_all();
    start = st;
    rst   = r;
    drive_random();
    @(posedge clk);
    model_edge();
  endtask

  // Assert reset between edges and confirm it takes effect without a clock
  task automatic async_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_w0",   w0,        INIT0);
    chk("async_w1",   w1,        32'h0);
    chk("async_w2",   w2,        32'h0);
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    n0 = 32'h0; n1 = 32'h0; n2 = 32'h0; n12 = 32'h0;
    model_reset();
    #2;
    check_all();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      if (m_run && (m_pos % PER >= FL) && (m_pos % PER < PER - 1) && ($urandom % 50 == 0))
        async_reset();
      else if (m_run)
        step(($urandom % 10 == 0), 1'b0);
      else
        step(($urandom % 3 == 0), 1'b0);
    end
    step(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_train_ctrl.md
# xor_train_ctrl

Training sequencer and weight register bank for the XOR perceptron. It holds the four hidden-to-output weights (V0, V1, V2, V12) and drives them to both the forward network and the weight-calculation stage. It steps through the four XOR patterns and waits out the fixed pipeline latencies of those stages. It then latches the updated weights from the weight-calculation stage, once per pattern, for a programmed number of epochs.

## Interface

Parameters:
- `EPOCHS`, 1000: number of full passes over the 4 patterns (1..65535).
- `FWD_LATENCY`, 30: cycles from stable weights/pattern until forward-net outputs (output, mid values) are valid (≥1).
- `UPD_LATENCY`, 20: cycles from valid forward outputs until the new-weight inputs are valid (≥1).
- `INIT_V0`, `INIT_V1`, `INIT_V2`, `INIT_V12`, 32'h00000000: IEEE-754 single reset values of the weights.

Ports:
- `iCLK`, in, 1: clock; all logic on the rising edge.
- `iRST`, in, 1: asynchronous, active-high reset.
- `iSTART`, in, 1: start-training request, sampled per cycle.
- `iNEW_V0`, `iNEW_V1`, `iNEW_V2`, `iNEW_V12`, in, 32: updated weights from the weight-calculation stage.
- `oWEIGHT_V0`, `oWEIGHT_V1`, `oWEIGHT_V2`, `oWEIGHT_V12`, out, 32: current registered weights.
- `oX1`, `oX2`, out, 32: current pattern inputs as float (0.0 = 32'h00000000, 1.0 = 32'h3F800000).
- `oTEACH`, out, 32: teach value for the current pattern, float.
- `oPATTERN`, out, 2: current pattern index.
- `oEPOCH`, out, 16: completed-epoch count.
- `oBUSY`, out, 1: training in progress.
- `oUPDATE`, out, 1: one-cycle pulse in the cycle the weights are latched.
- `oDONE`, out, 1: training finished; held until the next start or reset.
- `oERR`, out, 1: sticky non-finite-weight flag (constant 0 unless the guard is compiled in).

## Operation

- Pattern table (index: X1, X2 → TEACH):
  - 0: 0, 0 → 0
  - 1: 0, 1 → 1
  - 2: 1, 0 → 1
  - 3: 1, 1 → 0
- `oX1`, `oX2` and `oTEACH` are registered decodes of `oPATTERN`.
- FSM states: `IDLE`, `FWD`, `UPD`, `LATCH`, `DONE`.
- `IDLE`/`DONE` with `iSTART`=1:
  - clear pattern, epoch, `oDONE` and `oERR`; go to `FWD` with the wait counter at 0.
  - Weights are not reloaded: training continues from the current weights.
- `FWD`: count `FWD_LATENCY` cycles, then go to `UPD`.
- `UPD`: count `UPD_LATENCY` cycles, then go to `LATCH`.
- `LATCH` (1 cycle):
  - weights <= `iNEW_*`; `oUPDATE`=1.
  - If pattern < 3: pattern+1, go to `FWD`.
  - If pattern = 3: pattern <= 0 and epoch+1. If the new epoch = `EPOCHS`, go to `DONE`, else go to `FWD`.
- `DONE`: `oDONE`=1, `oBUSY`=0; weights, `oEPOCH` = `EPOCHS` and pattern 0 are held.
- `iSTART` is ignored in `FWD`, `UPD` and `LATCH`.
- Weights, `oX*` and `oTEACH` change only on the edge that leaves `LATCH` or on reset. They are stable for the whole `FWD`+`UPD` window, because the downstream pipelines carry no valid signal.
- `oBUSY`=1 in `FWD`, `UPD` and `LATCH`.

## Timing

- Reset values:
  - `oWEIGHT_Vx` = `INIT_Vx`.
  - `oX1` = `oX2` = `oTEACH` = 0.
  - `oPATTERN`, `oEPOCH`, `oBUSY`, `oUPDATE`, `oDONE`, `oERR` = 0.
  - State = `IDLE`.
- `iRST` mid-operation aborts immediately (asynchronously) to these values, whatever the state.
- `iSTART` sampled high at edge N: `oBUSY`=1 from N.
- Per pattern: `FWD_LATENCY`+`UPD_LATENCY`+1 cycles. The first `oUPDATE` is high in the cycle starting at edge N+`FWD_LATENCY`+`UPD_LATENCY`.
- Total run: 4·`EPOCHS`·(`FWD_LATENCY`+`UPD_LATENCY`+1) cycles. `oDONE` rises on the edge after the last `LATCH` cycle; `oBUSY` falls on the same edge.
- `iSTART` held high through `DONE` starts a new run on the next edge. `oDONE` clears on that edge.
- The epoch counter is 16 bits; `EPOCHS` ≤ 65535, so it never wraps.

## Configuration

- `XOR_TRAIN_NAN_GUARD_EN` defined:
  - In `LATCH`, any `iNEW_Vx` with exponent 8'hFF (Inf/NaN) is not written; that weight keeps its old value.
  - `oERR` is set and stays set until reset or the next start. Other, finite weights still update.
- Not defined: all `iNEW_Vx` are latched unconditionally; `oERR` is tied to 0.

## Test plan

- Reset with `INIT_V0`=32'h3F000000, others 0: `oWEIGHT_V0`=32'h3F000000, other weights 0, `oBUSY`=`oDONE`=0, `oX1`=`oX2`=`oTEACH`=0.
- `EPOCHS`=2, `FWD_LATENCY`=3, `UPD_LATENCY`=4, one-cycle `iSTART` at edge 0:
  - `oUPDATE` pulses at cycles 7, 15, …, 63 (8 pulses total).
  - `oPATTERN` sequence 0,1,2,3,0,1,2,3; `oEPOCH` 1 after cycle 31.
  - `oDONE`=1 and `oBUSY`=0 from cycle 64, `oEPOCH`=2.
- Constant `iNEW_V1`=32'h40000000: `oWEIGHT_V1` changes only after the first `oUPDATE`. For pattern 2, `oX1`=32'h3F800000, `oX2`=0, `oTEACH`=32'h3F800000, constant over all 7 cycles.
- `iSTART` pulsed during `UPD` is ignored (pulse count unchanged). `iRST` asserted mid-`UPD` returns weights to `INIT_*` and `oBUSY` to 0 without waiting for a clock edge.
- `iNEW_V2`=32'h7FC00000, `iNEW_V0`=32'h3F800000:
  - With `XOR_TRAIN_NAN_GUARD_EN`: after `LATCH`, `oWEIGHT_V2` is unchanged, `oWEIGHT_V0`=32'h3F800000, `oERR`=1 (sticky).
  - Without it: `oWEIGHT_V2`=32'h7FC00000, `oERR`=0.
- Restart from `DONE` with `iSTART`: weights are retained (not `INIT_*`), `oEPOCH` clears to 0, `oDONE` clears the next cycle.
